// File: rtl/e203_exu_bjp_flush_ctrl.sv
// Redirect/flush controller on the BJP commit interface: detects redirects, registers the target,
// and holds the IFU flush request until it is acknowledged. Optional counters: E203_BJP_PERF_CNT_EN.
module e203_exu_bjp_flush_ctrl #(
  parameter int unsigned PC_W  = 32
`ifdef E203_BJP_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmt_i_valid,
  output logic            cmt_i_ready,
  input  logic            cmt_i_bjp,
  input  logic            cmt_i_mret,
  input  logic            cmt_i_dret,
  input  logic            cmt_i_fencei,
  input  logic            cmt_i_prdt,
  input  logic            cmt_i_rslv,
  input  logic            cmt_i_jalr,
  input  logic            cmt_i_rv32,
  input  logic [PC_W-1:0] cmt_i_pc,
  input  logic [PC_W-1:0] cmt_i_imm,
  input  logic [PC_W-1:0] cmt_i_rs1,
  input  logic [PC_W-1:0] csr_epc_r,
  input  logic [PC_W-1:0] csr_dpc_r,
  output logic            flush_o_req,
  input  logic            flush_o_ack,
  output logic [PC_W-1:0] flush_o_pc,
  output logic            flush_o_mispred
`ifdef E203_BJP_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_bjp_cnt
  , output logic [CNT_W-1:0] perf_mispred_cnt
`endif
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic            mispred;
  logic            need;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] target;

  always_comb begin
    accept  = cmt_i_valid && (state == IDLE);
    mispred = cmt_i_bjp && (cmt_i_prdt != cmt_i_rslv);
    need    = cmt_i_dret || cmt_i_mret || cmt_i_fencei || mispred;
  end

  // Target priority dret > mret > fencei > branch/jump; jump targets are halfword aligned.
  always_comb begin
    seq_pc    = cmt_i_pc + (cmt_i_rv32 ? PC_W'(4) : PC_W'(2));
    br_tgt    = (cmt_i_jalr ? cmt_i_rs1 : cmt_i_pc) + cmt_i_imm;
    br_tgt[0] = 1'b0;
    if (cmt_i_dret)        target = csr_dpc_r;
    else if (cmt_i_mret)   target = csr_epc_r;
    else if (cmt_i_fencei) target = seq_pc;
    else if (cmt_i_rslv)   target = br_tgt;
    else                   target = seq_pc;
  end

  always_comb begin
    state_nxt   = state;
    cmt_i_ready = 1'b0;
    flush_o_req = 1'b0;
    case (state)
      IDLE: begin
        cmt_i_ready = 1'b1;
        if (accept && need) state_nxt = FLUSH;
      end
      FLUSH: begin
        flush_o_req = 1'b1;
        if (flush_o_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      flush_o_pc      <= '0;
      flush_o_mispred <= 1'b0;
    end else begin
      state           <= state_nxt;
      flush_o_mispred <= accept && mispred;
      if (accept && need) flush_o_pc <= target;
    end
  end

`ifdef E203_BJP_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bjp_cnt     <= '0;
      perf_mispred_cnt <= '0;
    end else begin
      if (accept && cmt_i_bjp && (perf_bjp_cnt != '1))
        perf_bjp_cnt <= perf_bjp_cnt + CNT_W'(1);
      if (flush_o_mispred && (perf_mispred_cnt != '1))
        perf_mispred_cnt <= perf_mispred_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_e203_exu_bjp_flush_ctrl.sv
// Bench for e203_exu_bjp_flush_ctrl: directed scenarios plus randomized traffic against a
// transaction-level reference model (counters checked when E203_BJP_PERF_CNT_EN is defined).
module tb_e203_exu_bjp_flush_ctrl;
  localparam int unsigned PC_W = 32;
`ifdef E203_BJP_PERF_CNT_EN
  localparam int unsigned CNT_W = 4;
`endif

  logic            clk;
  logic            rst;
  logic            cmt_i_valid, cmt_i_ready, cmt_i_bjp, cmt_i_mret, cmt_i_dret, cmt_i_fencei;
  logic            cmt_i_prdt, cmt_i_rslv, cmt_i_jalr, cmt_i_rv32;
  logic [PC_W-1:0] cmt_i_pc, cmt_i_imm, cmt_i_rs1, csr_epc_r, csr_dpc_r;
  logic            flush_o_req, flush_o_ack, flush_o_mispred;
  logic [PC_W-1:0] flush_o_pc;
`ifdef E203_BJP_PERF_CNT_EN
  logic [CNT_W-1:0] perf_bjp_cnt, perf_mispred_cnt;
`endif

  e203_exu_bjp_flush_ctrl #(
    .PC_W (PC_W)
`ifdef E203_BJP_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmt_i_valid     (cmt_i_valid),
    .cmt_i_ready     (cmt_i_ready),
    .cmt_i_bjp       (cmt_i_bjp),
    .cmt_i_mret      (cmt_i_mret),
    .cmt_i_dret      (cmt_i_dret),
    .cmt_i_fencei    (cmt_i_fencei),
    .cmt_i_prdt      (cmt_i_prdt),
    .cmt_i_rslv      (cmt_i_rslv),
    .cmt_i_jalr      (cmt_i_jalr),
    .cmt_i_rv32      (cmt_i_rv32),
    .cmt_i_pc        (cmt_i_pc),
    .cmt_i_imm       (cmt_i_imm),
    .cmt_i_rs1       (cmt_i_rs1),
    .csr_epc_r       (csr_epc_r),
    .csr_dpc_r       (csr_dpc_r),
    .flush_o_req     (flush_o_req),
    .flush_o_ack     (flush_o_ack),
    .flush_o_pc      (flush_o_pc),
    .flush_o_mispred (flush_o_mispred)
`ifdef E203_BJP_PERF_CNT_EN
    , .perf_bjp_cnt    (perf_bjp_cnt)
    , .perf_mispred_cnt(perf_mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one flag for "redirect outstanding", the last redirect target, the
  // pending mispredict pulse and the event counts.
  bit              m_busy;
  logic [PC_W-1:0] m_pc;
  bit              m_mis;
`ifdef E203_BJP_PERF_CNT_EN
  int unsigned     m_bjp_cnt, m_mis_cnt;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`endif

  function automatic logic [PC_W-1:0] ref_target();
    logic [PC_W-1:0] nxt;
    logic [PC_W-1:0] jmp;
    nxt = cmt_i_pc + (cmt_i_rv32 ? 32'd4 : 32'd2);
    jmp = ((cmt_i_jalr ? cmt_i_rs1 : cmt_i_pc) + cmt_i_imm) & ~32'd1;
    if (cmt_i_dret)   return csr_dpc_r;
    if (cmt_i_mret)   return csr_epc_r;
    if (cmt_i_fencei) return nxt;
    return cmt_i_rslv ? jmp : nxt;
  endfunction

  task automatic model_step();
    bit take, wrong;
    if (rst) begin
      m_busy = 0; m_pc = '0; m_mis = 0;
`ifdef E203_BJP_PERF_CNT_EN
      m_bjp_cnt = 0; m_mis_cnt = 0;
`endif
    end else begin
      take  = cmt_i_valid && !m_busy;
      wrong = cmt_i_bjp && (cmt_i_prdt != cmt_i_rslv);
`ifdef E203_BJP_PERF_CNT_EN
      if (take && cmt_i_bjp) m_bjp_cnt = (m_bjp_cnt < CNT_MAX) ? m_bjp_cnt + 1 : CNT_MAX;
      if (m_mis)             m_mis_cnt = (m_mis_cnt < CNT_MAX) ? m_mis_cnt + 1 : CNT_MAX;
`endif
      m_mis = take && wrong;
      if (m_busy) begin
        if (flush_o_ack) m_busy = 0;
      end else if (take && (cmt_i_dret || cmt_i_mret || cmt_i_fencei || wrong)) begin
        m_busy = 1;
        m_pc   = ref_target();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("ready",   {63'd0, cmt_i_ready},     {63'd0, !m_busy});
    check("req",     {63'd0, flush_o_req},     {63'd0, m_busy});
    check("pc",      {32'd0, flush_o_pc},      {32'd0, m_pc});
    check("mispred", {63'd0, flush_o_mispred}, {63'd0, m_mis});
`ifdef E203_BJP_PERF_CNT_EN
    check("bjp_cnt", {60'd0, perf_bjp_cnt},     64'(m_bjp_cnt));
    check("mis_cnt", {60'd0, perf_mispred_cnt}, 64'(m_mis_cnt));
`endif
  endtask

  task automatic clear_in();
    cmt_i_valid = 0; cmt_i_bjp = 0; cmt_i_mret = 0; cmt_i_dret = 0; cmt_i_fencei = 0;
    cmt_i_prdt = 0; cmt_i_rslv = 0; cmt_i_jalr = 0; cmt_i_rv32 = 1;
    cmt_i_pc = '0; cmt_i_imm = '0; cmt_i_rs1 = '0; flush_o_ack = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    csr_epc_r = 32'h80; csr_dpc_r = 32'h9000;
    do_reset();
    check("rst_req", {63'd0, flush_o_req}, 64'd0);
    check("rst_pc",  {32'd0, flush_o_pc},  64'd0);
    check("rst_rdy", {63'd0, cmt_i_ready}, 64'd1);

    // 1: taken mispredict, direct branch
    cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_rslv = 1; cmt_i_pc = 32'h1000; cmt_i_imm = 32'h40;
    tick(); clear_in();
    check("t1_req", {63'd0, flush_o_req}, 64'd1);
    check("t1_pc",  {32'd0, flush_o_pc},  64'h1040);
    check("t1_mis", {63'd0, flush_o_mispred}, 64'd1);
    flush_o_ack = 1; tick(); flush_o_ack = 0;
    check("t1_idle", {63'd0, cmt_i_ready}, 64'd1);

    // 2: not-taken mispredict, 16-bit, held flush with a stalled second record
    cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_prdt = 1; cmt_i_rv32 = 0; cmt_i_pc = 32'h2002;
    tick();
    check("t2_pc", {32'd0, flush_o_pc}, 64'h2004);
    cmt_i_prdt = 0; cmt_i_pc = 32'h2100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_req", {63'd0, flush_o_req}, 64'd1);
      check("t2_hold_rdy", {63'd0, cmt_i_ready}, 64'd0);
    end
    flush_o_ack = 1; tick(); flush_o_ack = 0;
    tick(); clear_in();
    check("t2_no_flush", {63'd0, flush_o_req}, 64'd0);

    // 3: jalr target with bit 0 cleared
    cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_jalr = 1; cmt_i_rslv = 1;
    cmt_i_rs1 = 32'h3001; cmt_i_imm = 32'h4;
    tick(); clear_in();
    check("t3_pc", {32'd0, flush_o_pc}, 64'h3004);
    flush_o_ack = 1; tick(); flush_o_ack = 0;

    // 4: mret + fencei -> mepc wins; then a correctly predicted branch
    cmt_i_valid = 1; cmt_i_mret = 1; cmt_i_fencei = 1; cmt_i_pc = 32'h500;
    tick(); clear_in();
    check("t4_pc",  {32'd0, flush_o_pc},      64'h80);
    check("t4_mis", {63'd0, flush_o_mispred}, 64'd0);
    flush_o_ack = 1; tick(); clear_in();
    cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_prdt = 1; cmt_i_rslv = 1; cmt_i_pc = 32'h600;
    tick(); clear_in();
    check("t4_rdy", {63'd0, cmt_i_ready}, 64'd1);
    check("t4_req", {63'd0, flush_o_req}, 64'd0);

    // 5: fence.i wrap-around, then reset during FLUSH
    cmt_i_valid = 1; cmt_i_fencei = 1; cmt_i_pc = 32'hFFFF_FFFC;
    tick(); clear_in();
    check("t5_pc",  {32'd0, flush_o_pc},  64'h0);
    check("t5_req", {63'd0, flush_o_req}, 64'd1);
    rst = 1; tick(); rst = 0;
    check("t5_rst_req", {63'd0, flush_o_req}, 64'd0);
    check("t5_rst_rdy", {63'd0, cmt_i_ready}, 64'd1);

`ifdef E203_BJP_PERF_CNT_EN
    // 6: three branches, one mispredicted; then saturation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_rslv = 1; cmt_i_prdt = (i != 2);
      cmt_i_pc = 32'h700 + 32'(i * 4); cmt_i_imm = 32'h10;
      tick();
    end
    clear_in(); tick();
    flush_o_ack = 1; tick(); clear_in(); tick();
    check("t6_bjp", {60'd0, perf_bjp_cnt},     64'd3);
    check("t6_mis", {60'd0, perf_mispred_cnt}, 64'd1);
    cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_prdt = 1; cmt_i_rslv = 1;
    for (int i = 0; i < 20; i++) tick();
    clear_in(); tick();
    check("t6_sat", {60'd0, perf_bjp_cnt}, 64'hF);
`endif

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cmt_i_valid  = ($urandom_range(9) < 7);
      cmt_i_bjp    = $urandom_range(1);
      cmt_i_mret   = ($urandom_range(7) == 0);
      cmt_i_dret   = ($urandom_range(9) == 0);
      cmt_i_fencei = ($urandom_range(7) == 0);
      cmt_i_prdt   = $urandom_range(1);
      cmt_i_rslv   = $urandom_range(1);
      cmt_i_jalr   = $urandom_range(1);
      cmt_i_rv32   = $urandom_range(1);
      cmt_i_pc     = ($urandom_range(15) == 0) ? 32'hFFFF_FFFE - 32'($urandom_range(4)) : $urandom;
      cmt_i_imm    = $urandom;
      cmt_i_rs1    = $urandom;
      csr_epc_r    = $urandom;
      csr_dpc_r    = $urandom;
      flush_o_ack  = ($urandom_range(9) < 3);
      rst          = ($urandom_range(99) == 0);
      tick();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
